// File: rtl/tank_pkg.sv
// Shared map geometry and arbiter state encoding for the tank game map port.
package tank_pkg;

  localparam int unsigned MAP_COLS = 64;
  localparam int unsigned MAP_ROWS = 44;
  localparam int unsigned ADDR_W   = 12;

  typedef enum logic {
    S_DISP,
    S_GAME
  } map_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches from ptr+1 (mod N) and returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[IDX_W'(j)]) begin
        found             = 1'b1;
        gnt[IDX_W'(j)]    = 1'b1;
        idx               = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the single-port wall-map RAM between the display scan and N_REQ game requesters.
// The display always wins; game requesters are served round-robin when the display is idle.
module map_port_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned MAP_COLS = tank_pkg::MAP_COLS,
  parameter int unsigned MAP_ROWS = tank_pkg::MAP_ROWS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vga_buzy,
  input  logic [5:0]                       vga_req_x,
  input  logic [5:0]                       vga_req_y,
  output logic                             vga_is_wall,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][5:0]            req_x,
  input  logic [N_REQ-1:0][5:0]            req_y,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ-1:0]                 req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             rsp_valid,
  output logic [1:0]                       rsp_id,
  output logic                             rsp_wall,
  output logic [tank_pkg::ADDR_W-1:0]      mem_addr,
  output logic                             mem_we,
  output logic                             mem_wdata,
  input  logic                             mem_rd_data
);
  import tank_pkg::*;

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  map_state_e       state_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             rd_pend_q;
  logic             rd_oob_q;
  logic [1:0]       rsp_id_q;
  logic             grant;
  logic [5:0]       sel_x;
  logic [5:0]       sel_y;
  logic             sel_we;
  logic             sel_wdata;
  logic             sel_oob;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (last_grant_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = (!rst && !vga_buzy) ? gnt : '0;
  assign grant     = |req_ready;

  assign sel_x     = req_x[gnt_idx];
  assign sel_y     = req_y[gnt_idx];
  assign sel_we    = req_we[gnt_idx];
  assign sel_wdata = req_wdata[gnt_idx];
  // Anything off the playable map reads as border wall and is never written.
  assign sel_oob   = (32'(sel_y) >= MAP_ROWS) || (32'(sel_x) >= MAP_COLS);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (vga_buzy) begin
      mem_addr = {vga_req_y, vga_req_x};
    end else if (grant) begin
      mem_addr  = {sel_y, sel_x};
      mem_we    = sel_we & ~sel_oob;
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_GAME;
      last_grant_q <= IDX_W'(N_REQ - 1);
      rd_pend_q    <= 1'b0;
      rd_oob_q     <= 1'b0;
      rsp_id_q     <= 2'd0;
      vga_is_wall  <= 1'b0;
    end else begin
      state_q <= vga_buzy ? S_DISP : S_GAME;
      // RAM data now reflects last cycle's address, so only take it after a display cycle.
      if (state_q == S_DISP) begin
        vga_is_wall <= mem_rd_data;
      end
      rd_pend_q <= grant & ~sel_we;
      if (grant) begin
        last_grant_q <= gnt_idx;
        if (!sel_we) begin
          rsp_id_q <= 2'(gnt_idx);
          rd_oob_q <= sel_oob;
        end
      end
    end
  end

  // A response still in flight when reset arrives is suppressed.
  assign rsp_valid = rd_pend_q & ~rst;
  assign rsp_wall  = rsp_valid & (rd_oob_q | mem_rd_data);
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter: a RAM model, requester agents and a per-cycle monitor.
module tb_map_port_arbiter;

  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            vga_buzy = 1'b0;
  logic [5:0]      vga_req_x = '0;
  logic [5:0]      vga_req_y = '0;
  logic            vga_is_wall;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0][5:0] req_x = '0;
  logic [N-1:0][5:0] req_y = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            rsp_wall;
  logic [11:0]     mem_addr;
  logic            mem_we;
  logic            mem_wdata;
  logic            mem_rd_data = 1'b0;

  always #5 clk = ~clk;

  map_port_arbiter #(
    .N_REQ    (N),
    .MAP_COLS (64),
    .MAP_ROWS (44)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_buzy    (vga_buzy),
    .vga_req_x   (vga_req_x),
    .vga_req_y   (vga_req_y),
    .vga_is_wall (vga_is_wall),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_wall    (rsp_wall),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rd_data (mem_rd_data)
  );

  // Map RAM (environment) and an independent expected copy.
  logic ram     [4096];
  logic exp_mem [4096];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rd_data <= ram[mem_addr];
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester agents: per-requester transaction program, head advances on accept.
  typedef struct packed {
    logic       we;
    logic       wdata;
    logic [5:0] x;
    logic [5:0] y;
  } txn_t;

  txn_t     prog [N][32];
  int       cnt  [N];
  int       head [N];
  logic [N-1:0] acc = '0;

  typedef struct packed {
    logic [1:0] id;
    logic       wall;
  } rsp_t;

  rsp_t exp_q[$];

  task automatic push_txn(input int r, input logic we, input logic wd, input int x, input int y);
    txn_t t;
    t.we = we; t.wdata = wd; t.x = 6'(x); t.y = 6'(y);
    prog[r][cnt[r]] = t;
    cnt[r]++;
  endtask

  task automatic tick();
    txn_t t;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        head[i]++;
        acc[i] = 1'b0;
      end
      if (head[i] < cnt[i]) begin
        t = prog[i][head[i]];
        req_valid[i] = 1'b1;
        req_we[i]    = t.we;
        req_wdata[i] = t.wdata;
        req_x[i]     = t.x;
        req_y[i]     = t.y;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (head[i] < cnt[i]) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      tick();
      k++;
    end
    check_eq("idle_timeout", 32'(busy()), 0);
  endtask

  // Monitor / reference model, evaluated mid-cycle.
  logic [1:0] m_ptr   = 2'd2;
  logic       m_disp  = 1'b0;
  logic       m_vw    = 1'b0;
  logic       m_rdval = 1'b0;

  always @(negedge clk) begin : monitor
    logic [N-1:0] eg;
    int           gi;
    int           j;
    rsp_t         e;
    logic         oob;
    logic [11:0]  a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) begin
        check_eq("rsp_drop_on_rst", 32'(rsp_valid), 0);
      end else begin
        check_eq("rsp_valid", 32'(rsp_valid), 1);
        check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
        check_eq("rsp_wall", 32'(rsp_wall), 32'(e.wall));
      end
    end else begin
      check_eq("rsp_idle", 32'(rsp_valid), 0);
    end
    check_eq("vga_is_wall", 32'(vga_is_wall), 32'(m_vw));

    eg = '0;
    gi = -1;
    if (!rst && !vga_buzy) begin
      for (int k = 1; k <= N; k++) begin
        j = (int'(m_ptr) + k) % N;
        if (gi < 0 && req_valid[j]) gi = j;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(eg));
    for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) acc[i] = 1'b1;

    if (vga_buzy) begin
      check_eq("disp_addr", 32'(mem_addr), 32'({vga_req_y, vga_req_x}));
      check_eq("disp_we", 32'(mem_we), 0);
    end else if (gi < 0) begin
      check_eq("idle_we", 32'(mem_we), 0);
    end

    if (gi >= 0) begin
      m_ptr = 2'(gi);
      a     = {req_y[gi], req_x[gi]};
      oob   = (req_y[gi] >= 6'd44);
      if (req_we[gi]) begin
        check_eq("wr_we", 32'(mem_we), 32'(!oob));
        if (!oob) begin
          check_eq("wr_addr", 32'(mem_addr), 32'(a));
          check_eq("wr_data", 32'(mem_wdata), 32'(req_wdata[gi]));
          exp_mem[a] = req_wdata[gi];
        end
      end else begin
        check_eq("rd_we", 32'(mem_we), 0);
        if (!oob) check_eq("rd_addr", 32'(mem_addr), 32'(a));
        e.id   = 2'(gi);
        e.wall = oob ? 1'b1 : exp_mem[a];
        exp_q.push_back(e);
      end
    end

    if (rst) begin
      m_ptr  = 2'(N - 1);
      m_vw   = 1'b0;
      m_disp = 1'b0;
      exp_q.delete();
    end else begin
      if (m_disp) m_vw = m_rdval;
      m_disp = vga_buzy;
      if (vga_buzy) m_rdval = exp_mem[{vga_req_y, vga_req_x}];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram[a]     = (a % 5 == 0);
      exp_mem[a] = (a % 5 == 0);
    end
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      head[i] = 0;
    end

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_id", 32'(rsp_id), 0);
    check_eq("rst_rsp_wall", 32'(rsp_wall), 0);
    check_eq("rst_vga_is_wall", 32'(vga_is_wall), 0);

    // Display owns the port for 20 cycles with all requesters pending, then round-robin reads
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) push_txn(i, 1'b0, 1'b0, 3 * i + k, 10 + k);
    vga_buzy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      vga_req_x = 6'((k * 7) % 64);
      vga_req_y = 6'((k * 3) % 44);
    end
    tick();
    vga_buzy = 1'b0;
    wait_idle(100);

    // Requester 1 writes a wall, requester 2 reads it back; also clear a wall and read it
    push_txn(1, 1'b1, 1'b1, 5, 7);
    wait_idle(20);
    push_txn(2, 1'b0, 1'b0, 5, 7);
    wait_idle(20);
    push_txn(0, 1'b1, 1'b0, 10, 0);
    wait_idle(20);
    push_txn(0, 1'b0, 1'b0, 10, 0);
    wait_idle(20);

    // Out-of-range accesses and the last in-range row
    push_txn(0, 1'b0, 1'b0, 3, 50);
    push_txn(2, 1'b1, 1'b1, 1, 44);
    push_txn(1, 1'b0, 1'b0, 1, 43);
    wait_idle(30);
    push_txn(2, 1'b0, 1'b0, 1, 44);
    wait_idle(20);

    // Display rises in the same cycle the request appears: display wins
    push_txn(1, 1'b0, 1'b0, 2, 2);
    tick();
    vga_buzy  = 1'b1;
    vga_req_x = 6'd20;
    vga_req_y = 6'd20;
    for (int k = 0; k < 3; k++) begin
      tick();
      vga_req_x = 6'(21 + k);
    end
    tick();
    vga_buzy = 1'b0;
    wait_idle(20);

    // Read granted in the cycle before the display starts
    push_txn(0, 1'b0, 1'b0, 9, 9);
    tick();
    tick();
    vga_buzy  = 1'b1;
    vga_req_x = 6'd0;
    vga_req_y = 6'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vga_req_x = 6'(5 * (k + 1));
    end
    tick();
    vga_buzy = 1'b0;
    wait_idle(20);

    // Reset right after a read grant drops the response; pointer restarts at requester 0
    push_txn(1, 1'b0, 1'b0, 4, 4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = N - 1; i >= 0; i--) push_txn(i, 1'b0, 1'b0, 30 + i, 20);
    wait_idle(30);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
